// File: rtl/tag_cam.sv
// ---------------------------------------------------------------------------
// tag_cam : fully-associative tag store with valid bits, internal victim
//           selection, registered lookup and occupancy count.
// Build option: TAG_CAM_PLRU_EN selects tree pseudo-LRU over round-robin.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tag_cam #(
  parameter int ENTRIES  = 256,
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 4,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = ADDR_W - OFFSET_W
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              Lookup_Valid,
  input  logic [ADDR_W-1:0] Lookup_Addr,
  output logic              Hit,
  output logic [IDX_W-1:0]  Hit_Index,
  input  logic              Fill_Valid,
  input  logic [ADDR_W-1:0] Fill_Addr,
  output logic [IDX_W-1:0]  Victim_Index,
  output logic              Victim_Valid,
  output logic [TAG_W-1:0]  Victim_Tag,
  input  logic              Inv_Valid,
  input  logic [IDX_W-1:0]  Inv_Index,
  input  logic              Flush,
  output logic [IDX_W:0]    Count
);

  logic [TAG_W-1:0]   r_tag [ENTRIES];
  logic [ENTRIES-1:0] r_valid;
  logic [IDX_W:0]     r_count;
  logic               r_hit;
  logic [IDX_W-1:0]   r_hit_idx;

  logic [TAG_W-1:0]   w_lu_tag;
  logic [TAG_W-1:0]   w_fill_tag;
  logic               w_any_match;
  logic [IDX_W-1:0]   w_match_idx;
  logic               w_any_free;
  logic [IDX_W-1:0]   w_free_idx;
  logic [IDX_W-1:0]   w_policy_idx;
  logic [IDX_W-1:0]   w_victim_idx;
  logic               w_hit;
  logic               w_full;
  logic [ENTRIES-1:0] w_valid_nxt;
  logic               w_inc;
  logic               w_dec;
  logic               w_unused;

  assign w_lu_tag   = Lookup_Addr[ADDR_W-1:OFFSET_W];
  assign w_fill_tag = Fill_Addr[ADDR_W-1:OFFSET_W];
  assign w_unused   = ^{Lookup_Addr[OFFSET_W-1:0], Fill_Addr[OFFSET_W-1:0]};

  // Descending scans so the lowest qualifying index is the last one written.
  always_comb begin
    w_any_match = 1'b0;
    w_match_idx = '0;
    w_any_free  = 1'b0;
    w_free_idx  = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && (r_tag[i] == w_lu_tag)) begin
        w_any_match = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!r_valid[i]) begin
        w_any_free = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  assign w_hit        = Lookup_Valid && w_any_match;
  assign w_full       = ~w_any_free;
  assign w_victim_idx = w_any_free ? w_free_idx : w_policy_idx;

`ifdef TAG_CAM_PLRU_EN
  // Node n (1-based heap order) lives at bit n-1; a 0 bit points to the left child.
  logic [ENTRIES-2:0] r_plru;
  logic [ENTRIES-2:0] w_plru_nxt;

  function automatic logic [ENTRIES-2:0] plru_touch(input logic [ENTRIES-2:0] bits,
                                                    input logic [IDX_W-1:0]   idx);
    logic [ENTRIES-2:0] b;
    int node;
    b    = bits;
    node = 1;
    for (int lvl = 0; lvl < IDX_W; lvl++) begin
      b[node-1] = ~idx[IDX_W-1-lvl];
      node      = 2 * node + int'(idx[IDX_W-1-lvl]);
    end
    return b;
  endfunction

  always_comb begin
    int node;
    node = 1;
    for (int lvl = 0; lvl < IDX_W; lvl++) begin
      node = 2 * node + int'(r_plru[node-1]);
    end
    w_policy_idx = IDX_W'(node - ENTRIES);
  end

  always_comb begin
    w_plru_nxt = r_plru;
    if (w_hit) begin
      w_plru_nxt = plru_touch(w_plru_nxt, w_match_idx);
    end
    if (Fill_Valid) begin
      w_plru_nxt = plru_touch(w_plru_nxt, w_victim_idx);
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset || Flush) begin
      r_plru <= '0;
    end else begin
      r_plru <= w_plru_nxt;
    end
  end
`else
  logic [IDX_W-1:0] r_rr_ptr;

  assign w_policy_idx = r_rr_ptr;

  always_ff @(posedge CLK) begin
    if (Reset || Flush) begin
      r_rr_ptr <= '0;
    end else if (Fill_Valid && w_full) begin
      r_rr_ptr <= r_rr_ptr + 1'b1;
    end
  end
`endif

  // Fill is applied after invalidate so a same-index pair leaves the entry valid.
  always_comb begin
    w_valid_nxt = r_valid;
    if (Inv_Valid) begin
      w_valid_nxt[Inv_Index] = 1'b0;
    end
    if (Fill_Valid) begin
      w_valid_nxt[w_victim_idx] = 1'b1;
    end
  end

  assign w_inc = Fill_Valid && !r_valid[w_victim_idx];
  assign w_dec = Inv_Valid && r_valid[Inv_Index] &&
                 !(Fill_Valid && (Inv_Index == w_victim_idx));

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_valid   <= '0;
      r_count   <= '0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
    end else begin
      r_hit     <= w_hit && !Flush;
      r_hit_idx <= (w_hit && !Flush) ? w_match_idx : '0;
      if (Flush) begin
        r_valid <= '0;
        r_count <= '0;
      end else begin
        r_valid <= w_valid_nxt;
        r_count <= r_count + (IDX_W+1)'(w_inc) - (IDX_W+1)'(w_dec);
      end
    end
  end

  // Tag storage carries no reset; only the valid bits qualify its contents.
  always_ff @(posedge CLK) begin
    if (Fill_Valid && !Flush && !Reset) begin
      r_tag[w_victim_idx] <= w_fill_tag;
    end
  end

  assign Hit          = r_hit;
  assign Hit_Index    = r_hit_idx;
  assign Victim_Index = w_victim_idx;
  assign Victim_Valid = r_valid[w_victim_idx];
  assign Victim_Tag   = r_tag[w_victim_idx];
  assign Count        = r_count;

endmodule

`default_nettype wire

// File: tb/tb_tag_cam.sv
// ---------------------------------------------------------------------------
// tb_tag_cam : directed self-checking bench for tag_cam (ENTRIES=8).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tag_cam;
  localparam int ENTRIES  = 8;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 4;
  localparam int IDX_W    = 3;
  localparam int TAG_W    = 28;

  logic              CLK = 1'b0;
  logic              Reset = 1'b1;
  logic              Lookup_Valid = 1'b0;
  logic [ADDR_W-1:0] Lookup_Addr = '0;
  logic              Hit;
  logic [IDX_W-1:0]  Hit_Index;
  logic              Fill_Valid = 1'b0;
  logic [ADDR_W-1:0] Fill_Addr = '0;
  logic [IDX_W-1:0]  Victim_Index;
  logic              Victim_Valid;
  logic [TAG_W-1:0]  Victim_Tag;
  logic              Inv_Valid = 1'b0;
  logic [IDX_W-1:0]  Inv_Index = '0;
  logic              Flush = 1'b0;
  logic [IDX_W:0]    Count;

  int n_cmp = 0;
  int n_bad = 0;

  tag_cam #(.ENTRIES(ENTRIES), .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W)) u_dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .Lookup_Valid (Lookup_Valid),
    .Lookup_Addr  (Lookup_Addr),
    .Hit          (Hit),
    .Hit_Index    (Hit_Index),
    .Fill_Valid   (Fill_Valid),
    .Fill_Addr    (Fill_Addr),
    .Victim_Index (Victim_Index),
    .Victim_Valid (Victim_Valid),
    .Victim_Tag   (Victim_Tag),
    .Inv_Valid    (Inv_Valid),
    .Inv_Index    (Inv_Index),
    .Flush        (Flush),
    .Count        (Count)
  );

  always #5 CLK = ~CLK;

  task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill(input logic [31:0] a);
    Fill_Valid = 1'b1;
    Fill_Addr  = a;
    tick();
    Fill_Valid = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] a);
    Lookup_Valid = 1'b1;
    Lookup_Addr  = a;
    tick();
    Lookup_Valid = 1'b0;
  endtask

  task automatic inval(input logic [IDX_W-1:0] idx);
    Inv_Valid = 1'b1;
    Inv_Index = idx;
    tick();
    Inv_Valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old5;

    tick();
    tick();
    Reset = 1'b0;
    check_eq("rst_hit",     64'(Hit),          64'd0);
    check_eq("rst_hit_idx", 64'(Hit_Index),    64'd0);
    check_eq("rst_count",   64'(Count),        64'd0);
    check_eq("rst_vidx",    64'(Victim_Index), 64'd0);
    check_eq("rst_vvalid",  64'(Victim_Valid), 64'd0);

    lookup(32'h1234_5670);
    check_eq("empty_hit",   64'(Hit),   64'd0);
    check_eq("empty_count", 64'(Count), 64'd0);

    fill(32'h1000_0000);
    fill(32'h2000_0000);
    lookup(32'h1000_0000);
    check_eq("lu0_hit", 64'(Hit),       64'd1);
    check_eq("lu0_idx", 64'(Hit_Index), 64'd0);
    lookup(32'h2000_0005);
    check_eq("lu1_hit", 64'(Hit),       64'd1);
    check_eq("lu1_idx", 64'(Hit_Index), 64'd1);
    check_eq("count2",  64'(Count),     64'd2);

    // Lookup coincident with its own fill sees the pre-edge contents.
    Fill_Valid = 1'b1; Fill_Addr = 32'h3000_0000;
    Lookup_Valid = 1'b1; Lookup_Addr = 32'h3000_0000;
    tick();
    Fill_Valid = 1'b0; Lookup_Valid = 1'b0;
    check_eq("samecyc_hit", 64'(Hit), 64'd0);
    check_eq("samecyc_idx", 64'(Hit_Index), 64'd0);
    lookup(32'h3000_0000);
    check_eq("lu2_hit", 64'(Hit),       64'd1);
    check_eq("lu2_idx", 64'(Hit_Index), 64'd2);

    for (int k = 3; k < ENTRIES; k++) begin
      check_eq("fill_vidx", 64'(Victim_Index), 64'(k));
      fill(32'(k + 1) << 28);
    end
    check_eq("full_count",  64'(Count),        64'd8);
    check_eq("full_vvalid", 64'(Victim_Valid), 64'd1);
    check_eq("full_vidx",   64'(Victim_Index), 64'd0);
    check_eq("full_vtag",   64'(Victim_Tag),   64'h100_0000);

`ifdef TAG_CAM_PLRU_EN
    lookup(32'h1000_0000);
    lookup(32'h5000_0000);
    check_eq("plru_hit4", 64'(Hit_Index),    64'd4);
    check_eq("plru_vidx", 64'(Victim_Index), 64'd2);
    old5 = 32'h6000_0000;
`else
    for (int k = 0; k < ENTRIES; k++) begin
      check_eq("rr_vidx", 64'(Victim_Index), 64'(k));
      fill(32'hA000_0000 | (32'(k) << 24));
      check_eq("rr_count", 64'(Count), 64'd8);
    end
    check_eq("rr_wrap",  64'(Victim_Index), 64'd0);
    check_eq("rr_vtag",  64'(Victim_Tag),   64'hA00_0000);
    lookup(32'hA100_0000);
    check_eq("rr_lu_hit", 64'(Hit),       64'd1);
    check_eq("rr_lu_idx", 64'(Hit_Index), 64'd1);
    old5 = 32'hA500_0000;
`endif

    inval(3'd5);
    check_eq("inv_count",  64'(Count),        64'd7);
    check_eq("inv_vidx",   64'(Victim_Index), 64'd5);
    check_eq("inv_vvalid", 64'(Victim_Valid), 64'd0);
    lookup(old5);
    check_eq("inv_lu_hit", 64'(Hit), 64'd0);

    // Fill and invalidate to the same index: the fill wins, so occupancy is back to full.
    Fill_Valid = 1'b1; Fill_Addr = 32'hB500_0000;
    Inv_Valid  = 1'b1; Inv_Index = 3'd5;
    tick();
    Fill_Valid = 1'b0; Inv_Valid = 1'b0;
    check_eq("fi_count",  64'(Count),        64'd8);
    check_eq("fi_vvalid", 64'(Victim_Valid), 64'd1);
    lookup(32'hB500_0000);
    check_eq("fi_lu_hit", 64'(Hit),       64'd1);
    check_eq("fi_lu_idx", 64'(Hit_Index), 64'd5);
`ifndef TAG_CAM_PLRU_EN
    check_eq("fi_vidx", 64'(Victim_Index), 64'd0);
`endif

    Flush = 1'b1;
    Fill_Valid = 1'b1; Fill_Addr = 32'hC000_0000;
    Lookup_Valid = 1'b1; Lookup_Addr = 32'hB500_0000;
    tick();
    Flush = 1'b0; Fill_Valid = 1'b0; Lookup_Valid = 1'b0;
    check_eq("fl_hit",    64'(Hit),          64'd0);
    check_eq("fl_count",  64'(Count),        64'd0);
    check_eq("fl_vidx",   64'(Victim_Index), 64'd0);
    check_eq("fl_vvalid", 64'(Victim_Valid), 64'd0);
    lookup(32'hB500_0000);
    check_eq("fl_lu_old", 64'(Hit), 64'd0);
    lookup(32'hC000_0000);
    check_eq("fl_lu_fill", 64'(Hit), 64'd0);
    inval(3'd3);
    check_eq("inv_empty_count", 64'(Count), 64'd0);

    fill(32'h5000_0000);
    fill(32'h5000_0008);
    check_eq("dup_count", 64'(Count), 64'd2);
    lookup(32'h5000_0000);
    check_eq("dup_hit", 64'(Hit),       64'd1);
    check_eq("dup_idx", 64'(Hit_Index), 64'd0);
    inval(3'd0);
    check_eq("dup_inv_count", 64'(Count),        64'd1);
    check_eq("dup_inv_vidx",  64'(Victim_Index), 64'd0);
    lookup(32'h5000_0000);
    check_eq("dup2_idx", 64'(Hit_Index), 64'd1);

    Reset = 1'b1;
    Lookup_Valid = 1'b1; Lookup_Addr = 32'h5000_0000;
    tick();
    Reset = 1'b0; Lookup_Valid = 1'b0;
    check_eq("mrst_hit",   64'(Hit),   64'd0);
    check_eq("mrst_count", 64'(Count), 64'd0);
    lookup(32'h5000_0000);
    check_eq("mrst_lu_hit", 64'(Hit), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
